// File: rtl/axi_dma_copy_engine_if.sv
// AXI4 read/write channel bundle between the DMA copy engine (master) and the AXI4 manager (slave).
// Handshake: a beat/address transfers on the rising edge where valid and ready are both high; the
// source keeps valid and its payload stable until then. B has no ready (the manager holds it high).
interface axi_dma_copy_engine_if #(
  parameter int DW = 64,
  parameter int AW = 32
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          bvalid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
           awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata,
    input  arready, rvalid, rdata, rlast, awready, wready, bvalid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
           awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata,
    output arready, rvalid, rdata, rlast, awready, wready, bvalid
  );
endinterface

// File: rtl/axi_dma_copy_engine.sv
// Memory-to-memory copy sequencer: per burst, read BURST_LEN beats into a local buffer, then write
// them out; repeats for the requested burst count and pulses done.
module axi_dma_copy_engine #(
  parameter int M_AXI_DATA_WIDTH = 64,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int BURST_LEN        = 16
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESET,
  input  logic                        dma_start_i,
  input  logic [M_AXI_ADDR_WIDTH-1:0] dma_src_addr_i,
  input  logic [M_AXI_ADDR_WIDTH-1:0] dma_dst_addr_i,
  input  logic [15:0]                 dma_burst_num_i,
  output logic                        dma_busy_o,
  output logic                        dma_done_o,
  output logic [2:0]                  fsm_state,
  axi_dma_copy_engine_if.master       axi_dma
);
  localparam int DW          = M_AXI_DATA_WIDTH;
  localparam int AW          = M_AXI_ADDR_WIDTH;
  localparam int BURST_BYTES = BURST_LEN * DW / 8;
  localparam int CW          = $clog2(BURST_LEN) + 1;
  localparam int IW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LEN_C      = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_C     = CW'(BURST_LEN - 1);
  localparam logic [AW-1:0] STEP       = AW'(BURST_BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BURST_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        state, state_n;
  logic          arvalid_q, rready_q, awvalid_q, wvalid_q, busy_q, done_q;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   remaining;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic [DW-1:0] buf_mem [BURST_LEN];
  logic          ar_hs, r_hs, aw_hs, w_hs;

  assign ar_hs = arvalid_q & axi_dma.arready;
  assign r_hs  = rready_q  & axi_dma.rvalid;
  assign aw_hs = awvalid_q & axi_dma.awready;
  assign w_hs  = wvalid_q  & axi_dma.wready;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (dma_start_i) state_n = (dma_burst_num_i == '0) ? DONE : RD_ADDR;
      RD_ADDR: if (ar_hs) state_n = RD_DATA;
      RD_DATA: if (r_hs && axi_dma.rlast) state_n = WR_ADDR;
      WR_ADDR: if (aw_hs) state_n = WR_DATA;
      WR_DATA: if (w_hs && wr_cnt == LAST_C) state_n = WR_RESP;
      WR_RESP: if (axi_dma.bvalid) state_n = (remaining == 16'd1) ? DONE : RD_ADDR;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are flops loaded from the next state, so they are glitch-free and
  // rise exactly one cycle after the event that moves the FSM.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      src_addr  <= '0;
      dst_addr  <= '0;
      remaining <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      state     <= state_n;
      arvalid_q <= (state_n == RD_ADDR);
      rready_q  <= (state_n == RD_DATA);
      awvalid_q <= (state_n == WR_ADDR);
      wvalid_q  <= (state_n == WR_DATA);
      busy_q    <= (state_n != IDLE);
      done_q    <= (state == DONE);
      // Burst-aligned start addresses keep every burst inside one 4KB page.
      if (state == IDLE && dma_start_i) begin
        src_addr  <= dma_src_addr_i & ALIGN_MASK;
        dst_addr  <= dma_dst_addr_i & ALIGN_MASK;
        remaining <= dma_burst_num_i;
      end
      if (ar_hs) rd_cnt <= '0;
      else if (r_hs && rd_cnt < LEN_C) rd_cnt <= rd_cnt + 1'b1;
      if (aw_hs) wr_cnt <= '0;
      else if (w_hs) wr_cnt <= wr_cnt + 1'b1;
      if (state == WR_RESP && axi_dma.bvalid) begin
        src_addr  <= src_addr + STEP;
        dst_addr  <= dst_addr + STEP;
        remaining <= remaining - 16'd1;
      end
    end
  end

  // Beats past BURST_LEN (a slave that overruns rlast) are accepted but discarded.
  always_ff @(posedge M_AXI_ACLK) begin
    if (r_hs && rd_cnt < LEN_C) buf_mem[rd_cnt[IW-1:0]] <= axi_dma.rdata;
  end

  assign axi_dma.arvalid = arvalid_q;
  assign axi_dma.araddr  = src_addr;
  assign axi_dma.arlen   = 8'(BURST_LEN - 1);
  assign axi_dma.arsize  = 3'($clog2(DW / 8));
  assign axi_dma.arburst = 2'b01;
  assign axi_dma.rready  = rready_q;
  assign axi_dma.awvalid = awvalid_q;
  assign axi_dma.awaddr  = dst_addr;
  assign axi_dma.awlen   = 8'(BURST_LEN - 1);
  assign axi_dma.awsize  = 3'($clog2(DW / 8));
  assign axi_dma.awburst = 2'b01;
  assign axi_dma.wvalid  = wvalid_q;
  assign axi_dma.wdata   = wvalid_q ? buf_mem[wr_cnt[IW-1:0]] : '0;

  assign dma_busy_o = busy_q;
  assign dma_done_o = done_q;
  assign fsm_state  = state;
endmodule

// File: tb/tb_axi_dma_copy_engine.sv
// Bench for axi_dma_copy_engine: an AXI slave with optional random stalls, a copy model that
// predicts addresses and data from start requests, and directed copy/reset/ignore-start scenarios.
module tb_axi_dma_copy_engine;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int LEN = 16;
  localparam int BB  = LEN * DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          dma_start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   burst_num;
  logic          busy, done;
  logic [2:0]    fsm_state;

  axi_dma_copy_engine_if #(.DW(DW), .AW(AW)) axi_bus ();

  axi_dma_copy_engine #(
    .M_AXI_DATA_WIDTH(DW), .M_AXI_ADDR_WIDTH(AW), .BURST_LEN(LEN)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .dma_start_i(dma_start),
    .dma_src_addr_i(src_addr), .dma_dst_addr_i(dst_addr), .dma_burst_num_i(burst_num),
    .dma_busy_o(busy), .dma_done_o(done), .fsm_state(fsm_state), .axi_dma(axi_bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Copy model: a started transfer of n bursts must read n aligned source bursts, write n
  // aligned destination bursts, and deliver source bytes to the destination in order.
  logic [AW-1:0] exp_ar_q[$];
  logic [AW-1:0] exp_aw_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_done = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic model_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [15:0] n);
    logic [AW-1:0] sb, db;
    sb = s - AW'(s % BB);
    db = d - AW'(d % BB);
    for (int k = 0; k < int'(n); k++) begin
      exp_ar_q.push_back(sb);
      exp_aw_q.push_back(db);
      for (int b = 0; b < LEN; b++) exp_q.push_back(mem_word(sb + AW'(b * (DW / 8))));
      sb = sb + AW'(BB);
      db = db + AW'(BB);
    end
    exp_done++;
  endtask

  // Observation logs and slave state
  logic [AW-1:0] ar_log[$];
  logic [AW-1:0] aw_log[$];
  int            w_cnt = 0, done_cnt = 0, bus_cycles = 0;
  logic [AW-1:0] rd_burst_q[$];
  int            rbeat = 0, wbeat = 0, b_delay = 0;
  bit            r_taken = 0, b_pending = 0, stall = 0;
  bit            ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic [AW-1:0] ar_prev, aw_prev;
  logic [DW-1:0] w_prev;

  // Slave + compare process: drives slave signals at negedge and checks every handshake
  // that will complete at the following posedge.
  initial begin
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0; axi_bus.rlast = 1'b0;
    axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_burst_q.delete();
        rbeat = 0; wbeat = 0; b_pending = 0; r_taken = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
      end else begin
        check("fixed_fields",
              64'({axi_bus.arlen, axi_bus.arsize, axi_bus.arburst, axi_bus.awlen, axi_bus.awsize, axi_bus.awburst}),
              64'({8'd15, 3'd3, 2'b01, 8'd15, 3'd3, 2'b01}));
        if (done) begin
          check("done_busy_low", 64'(busy), 64'd0);
          done_cnt++;
        end
        if (ar_wait) check("ar_hold", 64'({axi_bus.arvalid, axi_bus.araddr}), 64'({1'b1, ar_prev}));
        if (aw_wait) check("aw_hold", 64'({axi_bus.awvalid, axi_bus.awaddr}), 64'({1'b1, aw_prev}));
        if (w_wait) begin
          check("w_hold_valid", 64'(axi_bus.wvalid), 64'd1);
          check("w_hold_data", axi_bus.wdata, w_prev);
        end
        if (axi_bus.arvalid | axi_bus.awvalid | axi_bus.wvalid | axi_bus.rready) bus_cycles++;

        // B: single-cycle response some cycles after the last W beat
        axi_bus.bvalid = 1'b0;
        if (b_pending) begin
          if (b_delay == 0) begin axi_bus.bvalid = 1'b1; b_pending = 0; end
          else b_delay--;
        end
        // R: beats of the oldest accepted read burst; valid held until taken
        if (r_taken) begin axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0; r_taken = 0; end
        if (!axi_bus.rvalid && rd_burst_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
          axi_bus.rvalid = 1'b1;
          axi_bus.rdata  = mem_word(rd_burst_q[0] + AW'(rbeat * (DW / 8)));
          axi_bus.rlast  = (rbeat == LEN - 1);
        end
        if (axi_bus.rvalid && axi_bus.rready) begin
          r_taken = 1;
          rbeat++;
          if (rbeat == LEN) begin rbeat = 0; void'(rd_burst_q.pop_front()); end
        end
        // AR
        axi_bus.arready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        ar_wait = axi_bus.arvalid && !axi_bus.arready;
        ar_prev = axi_bus.araddr;
        if (axi_bus.arvalid && axi_bus.arready) begin
          ar_log.push_back(axi_bus.araddr);
          rd_burst_q.push_back(axi_bus.araddr);
          check("ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
          if (exp_ar_q.size() > 0) check("ar_addr", 64'(axi_bus.araddr), 64'(exp_ar_q.pop_front()));
        end
        // AW
        axi_bus.awready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        aw_wait = axi_bus.awvalid && !axi_bus.awready;
        aw_prev = axi_bus.awaddr;
        if (axi_bus.awvalid && axi_bus.awready) begin
          aw_log.push_back(axi_bus.awaddr);
          check("aw_expected", 64'(exp_aw_q.size() > 0), 64'd1);
          if (exp_aw_q.size() > 0) check("aw_addr", 64'(axi_bus.awaddr), 64'(exp_aw_q.pop_front()));
        end
        // W
        axi_bus.wready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        w_wait = axi_bus.wvalid && !axi_bus.wready;
        w_prev = axi_bus.wdata;
        if (axi_bus.wvalid && axi_bus.wready) begin
          w_cnt++;
          check("w_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("w_data", axi_bus.wdata, exp_q.pop_front());
          wbeat++;
          if (wbeat == LEN) begin
            wbeat = 0;
            b_pending = 1;
            b_delay = stall ? int'($urandom_range(0, 3)) : 0;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [15:0] n);
    @(posedge clk); #1;
    dma_start = 1'b1; src_addr = s; dst_addr = d; burst_num = n;
    model_start(s, d, n);
    @(posedge clk); #1;
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && done_cnt < exp_done; i++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(done_cnt), 64'(exp_done));
  endtask

  task automatic settle(input string name, input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
    check({name, "_ar_left"}, 64'(exp_ar_q.size()), 64'd0);
    check({name, "_w_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_single_done"}, 64'(done_cnt), 64'(exp_done));
    check({name, "_idle"}, 64'({busy, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid}), 64'd0);
  endtask

  task automatic clear_logs();
    ar_log.delete();
    aw_log.delete();
    w_cnt = 0;
  endtask

  function automatic logic [AW-1:0] ar_at(input int i);
    return (ar_log.size() > i) ? ar_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [AW-1:0] aw_at(input int i);
    return (aw_log.size() > i) ? aw_log[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int bus0;
    rst = 1'b1; dma_start = 1'b0; src_addr = '0; dst_addr = '0; burst_num = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", 64'({axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid, axi_bus.wvalid}), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_araddr", 64'(axi_bus.araddr), 64'd0);
    check("rst_awaddr", 64'(axi_bus.awaddr), 64'd0);
    check("rst_wdata", axi_bus.wdata, 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);
    check("rst_lens", 64'({axi_bus.arlen, axi_bus.awlen}), 64'h0F0F);
    check("rst_size_burst", 64'({axi_bus.arsize, axi_bus.arburst, axi_bus.awsize, axi_bus.awburst}),
          64'({3'd3, 2'b01, 3'd3, 2'b01}));
    rst = 1'b0;

    // 1: single burst, zero-wait slave
    stall = 0; clear_logs();
    do_start(32'h1000, 32'h2000, 16'd1);
    wait_done("t1_done", 400);
    settle("t1", 4);
    check("t1_ar_count", 64'(ar_log.size()), 64'd1);
    check("t1_ar0", 64'(ar_at(0)), 64'h1000);
    check("t1_aw0", 64'(aw_at(0)), 64'h2000);
    check("t1_w_count", 64'(w_cnt), 64'd16);

    // 2: three bursts with random stalls on every channel
    stall = 1; clear_logs();
    do_start(32'h1000, 32'h2000, 16'd3);
    wait_done("t2_done", 4000);
    settle("t2", 6);
    check("t2_ar_count", 64'(ar_log.size()), 64'd3);
    check("t2_ar0", 64'(ar_at(0)), 64'h1000);
    check("t2_ar1", 64'(ar_at(1)), 64'h1080);
    check("t2_ar2", 64'(ar_at(2)), 64'h1100);
    check("t2_aw2", 64'(aw_at(2)), 64'h2100);
    check("t2_w_count", 64'(w_cnt), 64'd48);

    // 3: zero bursts -> done two cycles after start, no bus activity
    stall = 0; clear_logs(); bus0 = bus_cycles;
    @(posedge clk); #1;
    dma_start = 1'b1; src_addr = 32'h1000; dst_addr = 32'h2000; burst_num = 16'd0;
    model_start(32'h1000, 32'h2000, 16'd0);
    @(posedge clk); #1;
    dma_start = 1'b0;
    check("t3_c1_busy_done", 64'({busy, done}), 64'b10);
    @(posedge clk); #1;
    check("t3_c2_busy_done", 64'({busy, done}), 64'b01);
    @(posedge clk); #1;
    check("t3_c3_done", 64'(done), 64'd0);
    settle("t3", 3);
    check("t3_no_bus", 64'(bus_cycles - bus0), 64'd0);

    // 4: misaligned source is aligned down; source near the top wraps to zero
    clear_logs();
    do_start(32'h1013, 32'h3005, 16'd1);
    wait_done("t4a_done", 400);
    settle("t4a", 3);
    check("t4a_ar0", 64'(ar_at(0)), 64'h1000);
    check("t4a_aw0", 64'(aw_at(0)), 64'h3000);
    clear_logs();
    do_start(32'hFFFF_FF80, 32'h4000, 16'd2);
    wait_done("t4b_done", 800);
    settle("t4b", 3);
    check("t4b_ar0", 64'(ar_at(0)), 64'hFFFF_FF80);
    check("t4b_ar1", 64'(ar_at(1)), 64'h0000_0000);
    check("t4b_aw1", 64'(aw_at(1)), 64'h4080);

    // 5: reset while the sixth write beat is on the bus
    clear_logs();
    do_start(32'h5000, 32'h6000, 16'd2);
    for (int i = 0; i < 400 && !(wbeat == 5 && axi_bus.wvalid); i++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_beat5", 64'(wbeat), 64'd5);
    rst = 1'b1;
    exp_ar_q.delete(); exp_aw_q.delete(); exp_q.delete();
    exp_done = done_cnt;
    @(posedge clk); #1;
    check("t5_after_rst", 64'({axi_bus.wvalid, busy, done, axi_bus.arvalid, axi_bus.rready}), 64'd0);
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("t5_no_done", 64'(done_cnt), 64'(exp_done));
    clear_logs();
    do_start(32'h5000, 32'h6000, 16'd1);
    wait_done("t5_restart_done", 400);
    settle("t5", 3);
    check("t5_restart_ar0", 64'(ar_at(0)), 64'h5000);

    // 6: start pulses while busy are ignored
    stall = 1; clear_logs();
    do_start(32'h7000, 32'h9000, 16'd2);
    repeat (3) begin @(posedge clk); #1; end
    dma_start = 1'b1; src_addr = 32'hA000; dst_addr = 32'hB000; burst_num = 16'd4;
    @(posedge clk); #1;
    dma_start = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    dma_start = 1'b1; src_addr = 32'hC000; burst_num = 16'd3;
    @(posedge clk); #1;
    dma_start = 1'b0;
    wait_done("t6_done", 3000);
    settle("t6", 40);
    check("t6_ar_count", 64'(ar_log.size()), 64'd2);
    check("t6_ar1", 64'(ar_at(1)), 64'h7080);
    check("t6_aw1", 64'(aw_at(1)), 64'h9080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
